spi_display_rx: RTL and testbench

- SPI slave that models the display-panel end of the video link.
- Receives the cs/dc/sclk/mosi stream produced by the video driver and decodes bytes (MSB first, sampled on the sclk rising edge).
- Interprets a SSD1306-style command subset.
- Writes data bytes into a page-organised framebuffer through a simple write port.
- Used as the display model in system simulation and as a loopback checker on the FPGA.

---
 rtl/spi_display_pkg.sv | 31 +++
 rtl/spi_display_rx_if.sv | 29 ++
 rtl/spi_byte_rx.sv | 88 ++++++++
 rtl/spi_display_rx.sv | 146 ++++++++++++++
 tb/tb_spi_display_rx.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_display_pkg.sv
// Shared definitions for the SPI display receiver.
// Contents:
//   - SSD1306-style command opcodes.
//   - The command FSM state enum.
//   - is_one_arg(): flags opcodes that carry one argument byte, which is
//     then discarded.
package spi_display_pkg;

    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
    localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
    localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;

    typedef enum logic [2:0] {
        StCmd,
        StColS,
        StColE,
        StPgS,
        StPgE,
        StSkip1
    } cmd_state_e;

    // Opcodes followed by exactly one argument byte that the model does not use.
    function automatic logic is_one_arg(input logic [7:0] op);
        case (op)
            8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h20: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_display_rx_if.sv
// Bus between the video driver (master) and the display model (slave).
// Signals:
//   - spi_cs, spi_dc, spi_sclk, spi_mosi: SPI stream, driven by the master.
//   - fb_we, fb_addr, fb_data: framebuffer write port, driven by the slave.
interface spi_display_rx_if #(
    parameter int unsigned COLS  = 128,
    parameter int unsigned PAGES = 8
);
    localparam int unsigned AW = $clog2(COLS * PAGES);

    logic          spi_cs;
    logic          spi_dc;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;

    modport master (
        output spi_cs, spi_dc, spi_sclk, spi_mosi,
        input  fb_we, fb_addr, fb_data
    );

    modport slave (
        input  spi_cs, spi_dc, spi_sclk, spi_mosi,
        output fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/spi_byte_rx.sv
// SPI byte receiver: synchronises the SPI inputs, detects sclk rising edges and
// assembles bytes MSB first.
// Ports:
//   - clk, rst_n: system clock, synchronous active-low reset.
//   - spi_cs, spi_dc, spi_sclk, spi_mosi: asynchronous SPI inputs.
//   - byte_stb: one-cycle pulse, the cycle after the 8th sclk rise.
//   - rx_byte: last completed byte.
//   - is_data: dc value sampled with the 8th bit.
module spi_byte_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs,
    input  logic       spi_dc,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       byte_stb,
    output logic [7:0] rx_byte,
    output logic       is_data
);

    logic [SYNC_STAGES-1:0] cs_sync_q, dc_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic [7:0]             shift_q;
    logic [2:0]             bit_cnt_q;
    logic                   byte_stb_q;
    logic [7:0]             byte_q;
    logic                   is_data_q;

    logic cs_s, dc_s, sclk_s, mosi_s, sclk_rise;
    logic [7:0] shift_next;

    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign dc_s       = dc_sync_q[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign shift_next = {shift_q[6:0], mosi_s};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;  // deselected out of reset
            dc_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            byte_stb_q  <= 1'b0;
            byte_q      <= 8'h00;
            is_data_q   <= 1'b0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                cs_sync_q[i]   <= cs_sync_q[i-1];
                dc_sync_q[i]   <= dc_sync_q[i-1];
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
            cs_sync_q[0]   <= spi_cs;
            dc_sync_q[0]   <= spi_dc;
            sclk_sync_q[0] <= spi_sclk;
            mosi_sync_q[0] <= spi_mosi;
            sclk_prev_q    <= sclk_s;
            byte_stb_q     <= 1'b0;

            if (cs_s) begin
                // Deselect drops any partial byte.
                bit_cnt_q <= 3'd0;
            end else if (sclk_rise) begin
                shift_q <= shift_next;
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_q  <= 3'd0;
                    byte_stb_q <= 1'b1;
                    byte_q     <= shift_next;
                    is_data_q  <= dc_s;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end
        end
    end

    assign byte_stb = byte_stb_q;
    assign rx_byte  = byte_q;
    assign is_data  = is_data_q;

endmodule

// File: rtl/spi_display_rx.sv
// SPI display-panel model: decodes an SSD1306-style command subset and writes
// data bytes into a page-organised framebuffer (address = page*COLS + col).
// Ports:
//   - clk, rst_n: system clock (>= 4x sclk), synchronous active-low reset.
//   - bus: SPI inputs and framebuffer write port (slave modport).
//   - disp_on: display enable state.
//   - rx_stb, rx_byte, rx_is_data: completed-byte pulse, byte and its dc flag.
module spi_display_rx
    import spi_display_pkg::*;
#(
    parameter int unsigned COLS        = 128,
    parameter int unsigned PAGES       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_display_rx_if.slave        bus,
    output logic                   disp_on,
    output logic                   rx_stb,
    output logic [7:0]             rx_byte,
    output logic                   rx_is_data
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned PW = $clog2(PAGES);

    logic       byte_stb;
    logic [7:0] byte_w;
    logic       is_data;

    spi_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_byte_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs   (bus.spi_cs),
        .spi_dc   (bus.spi_dc),
        .spi_sclk (bus.spi_sclk),
        .spi_mosi (bus.spi_mosi),
        .byte_stb (byte_stb),
        .rx_byte  (byte_w),
        .is_data  (is_data)
    );

    cmd_state_e    state_q, state_d;
    logic [CW-1:0] col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
    logic [PW-1:0] page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;
    logic          disp_on_q, disp_on_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StCmd;
            col_start_q  <= '0;
            col_end_q    <= CW'(COLS - 1);
            col_q        <= '0;
            page_start_q <= '0;
            page_end_q   <= PW'(PAGES - 1);
            page_q       <= '0;
            disp_on_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            col_q        <= col_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            page_q       <= page_d;
            disp_on_q    <= disp_on_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        col_d        = col_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        page_d       = page_q;
        disp_on_d    = disp_on_q;

        if (byte_stb) begin
            if (is_data) begin
                // A data byte also aborts any pending argument sequence.
                state_d = StCmd;
                if (col_q == col_end_q) begin
                    col_d = col_start_q;
                    if (page_q == page_end_q) begin
                        page_d = page_start_q;
                    end else begin
                        page_d = page_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                unique case (state_q)
                    StCmd: begin
                        if (byte_w == CMD_COL_ADDR) begin
                            state_d = StColS;
                        end else if (byte_w == CMD_PAGE_ADDR) begin
                            state_d = StPgS;
                        end else if (byte_w == CMD_DISP_ON) begin
                            disp_on_d = 1'b1;
                        end else if (byte_w == CMD_DISP_OFF) begin
                            disp_on_d = 1'b0;
                        end else if (is_one_arg(byte_w)) begin
                            state_d = StSkip1;
                        end
                    end
                    StColS: begin
                        col_start_d = byte_w[CW-1:0];
                        state_d     = StColE;
                    end
                    StColE: begin
                        col_end_d = byte_w[CW-1:0];
                        col_d     = col_start_q;
                        state_d   = StCmd;
                    end
                    StPgS: begin
                        page_start_d = byte_w[PW-1:0];
                        state_d      = StPgE;
                    end
                    StPgE: begin
                        page_end_d = byte_w[PW-1:0];
                        page_d     = page_start_q;
                        state_d    = StCmd;
                    end
                    StSkip1: state_d = StCmd;
                    default: state_d = StCmd;
                endcase
            end
        end
    end

    // Write port presents the pre-increment pointer in the rx_stb cycle.
    assign bus.fb_we   = byte_stb & is_data;
    assign bus.fb_addr = {page_q, col_q};
    assign bus.fb_data = byte_w;

    assign disp_on    = disp_on_q;
    assign rx_stb     = byte_stb;
    assign rx_byte    = byte_w;
    assign rx_is_data = is_data;

endmodule

// File: tb/tb_spi_display_rx.sv
// Scoreboard bench for spi_display_rx: stimulus pushes expected byte records,
// a negedge monitor pops and compares whenever rx_stb is seen.
module tb_spi_display_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic disp_on, rx_stb, rx_is_data;
    logic [7:0] rx_byte;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       d;
        logic [7:0] b;
        logic [9:0] a;
    } exp_t;

    exp_t exp_q[$];

    spi_display_rx_if #(.COLS(128), .PAGES(8)) bus ();

    spi_display_rx #(
        .COLS        (128),
        .PAGES       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .disp_on    (disp_on),
        .rx_stb     (rx_stb),
        .rx_byte    (rx_byte),
        .rx_is_data (rx_is_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed byte against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_stb) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_stb: got byte 0x%0h expected none", rx_byte);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rx_byte", 32'(rx_byte), 32'(e.b));
                    chk("rx_is_data", 32'(rx_is_data), 32'(e.d));
                    chk("fb_we", 32'(bus.fb_we), 32'(e.d));
                    if (e.d) begin
                        chk("fb_addr", 32'(bus.fb_addr), 32'(e.a));
                        chk("fb_data", 32'(bus.fb_data), 32'(e.b));
                    end
                end
            end else if (bus.fb_we) begin
                chk("fb_we_without_stb", 32'(bus.fb_we), 32'd0);
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.spi_mosi = b;
        wclk(4);
        bus.spi_sclk = 1'b1;
        wclk(4);
        bus.spi_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b, input logic [9:0] a);
        exp_t e;
        e.d = d;
        e.b = b;
        e.a = a;
        exp_q.push_back(e);
        bus.spi_dc = d;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wclk(6);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.spi_cs = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_dc = 1'b0;
        wclk(4);
        rst_n = 1'b1;
        wclk(2);
    endtask

    task automatic chk_zero_state(input string tag);
        @(negedge clk);
        chk({tag, "_rx_stb"}, 32'(rx_stb), 32'd0);
        chk({tag, "_fb_we"}, 32'(bus.fb_we), 32'd0);
        chk({tag, "_fb_addr"}, 32'(bus.fb_addr), 32'd0);
        chk({tag, "_fb_data"}, 32'(bus.fb_data), 32'd0);
        chk({tag, "_disp_on"}, 32'(disp_on), 32'd0);
        chk({tag, "_rx_byte"}, 32'(rx_byte), 32'd0);
        chk({tag, "_rx_is_data"}, 32'(rx_is_data), 32'd0);
        wclk(1);
    endtask

    initial begin
        bus.spi_cs = 1'b1;
        bus.spi_dc = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;

        // Reset state
        do_reset();
        chk_zero_state("reset");

        // Display on/off
        bus.spi_cs = 1'b0;
        wclk(2);
        send_byte(1'b0, 8'hAF, 10'd0);
        chk("disp_on_after_AF", 32'(disp_on), 32'd1);
        send_byte(1'b0, 8'hAE, 10'd0);
        chk("disp_on_after_AE", 32'(disp_on), 32'd0);
        bus.spi_cs = 1'b1;
        wclk(4);

        // Plain data writes from the reset pointer
        do_reset();
        bus.spi_cs = 1'b0;
        wclk(2);
        send_byte(1'b1, 8'h11, 10'd0);
        send_byte(1'b1, 8'h22, 10'd1);

        // Window cols 126..127, pages 6..7 with wrap
        send_byte(1'b0, 8'h21, 10'd0);
        send_byte(1'b0, 8'h7E, 10'd0);
        send_byte(1'b0, 8'h7F, 10'd0);
        send_byte(1'b0, 8'h22, 10'd0);
        send_byte(1'b0, 8'h06, 10'd0);
        send_byte(1'b0, 8'h07, 10'd0);
        send_byte(1'b1, 8'h01, 10'd894);
        send_byte(1'b1, 8'h02, 10'd895);
        send_byte(1'b1, 8'h03, 10'd1022);
        send_byte(1'b1, 8'h04, 10'd1023);
        send_byte(1'b1, 8'h05, 10'd894);

        // Partial byte dropped by cs deassertion
        bus.spi_dc = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        wclk(2);
        bus.spi_cs = 1'b1;
        wclk(6);
        bus.spi_cs = 1'b0;
        wclk(4);
        send_byte(1'b1, 8'hA5, 10'd895);
        bus.spi_cs = 1'b1;
        wclk(4);

        // 0x81 swallows the following 0x21 as its argument
        do_reset();
        bus.spi_cs = 1'b0;
        wclk(2);
        send_byte(1'b0, 8'h81, 10'd0);
        send_byte(1'b0, 8'h21, 10'd0);
        send_byte(1'b1, 8'h66, 10'd0);

        // Data byte aborts a column-address sequence
        send_byte(1'b0, 8'h21, 10'd0);
        send_byte(1'b1, 8'h55, 10'd1);
        send_byte(1'b0, 8'hAF, 10'd0);
        chk("disp_on_after_abort", 32'(disp_on), 32'd1);
        send_byte(1'b1, 8'h77, 10'd2);

        // Reset mid-byte
        bus.spi_dc = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst_n = 1'b0;
        wclk(3);
        chk_zero_state("midreset");
        rst_n = 1'b1;
        wclk(2);
        bus.spi_cs = 1'b0;
        wclk(2);
        send_byte(1'b1, 8'h3C, 10'd0);
        bus.spi_cs = 1'b1;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wclk(1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
